// File: rtl/arb_pkg.sv
// Shared types and the round-robin priority search used by the 4-way arbiter.
package arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Searches ptr+1, ptr+2, ptr+3, then ptr itself unless exclude is set.
  function automatic pick_t next_owner(input logic [N_REQ-1:0] req,
                                       input logic [1:0]       ptr,
                                       input logic             exclude);
    pick_t      p;
    logic [1:0] cand;
    p = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ptr + 2'(k);
      if (!p.found && req[cand] && !(exclude && (k == N_REQ))) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/decoder_2to4_bh.sv
// Enabled 2-to-4 one-hot decoder; output is all zero while en is low.
module decoder_2to4_bh (
  input  logic [1:0] in,
  input  logic       en,
  output logic [3:0] out
);

  always_comb begin
    out = 4'b0000;
    if (en) begin
      case (in)
        2'd0:    out = 4'b0001;
        2'd1:    out = 4'b0010;
        2'd2:    out = 4'b0100;
        2'd3:    out = 4'b1000;
        default: out = 4'b0000;
      endcase
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a hold limit that forces handover
// when the current owner has kept the grant for MAX_HOLD cycles under contention.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);

  state_e           state_q, state_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             preempt_q, preempt_d;
  pick_t            pick;

  always_comb begin
    state_d     = state_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    preempt_d   = 1'b0;
    pick        = '0;

    case (state_q)
      IDLE: begin
        pick = next_owner(req, ptr_q, 1'b0);
        if (pick.found) begin
          gnt_id_d    = pick.idx;
          gnt_valid_d = 1'b1;
          ptr_d       = pick.idx;
          hold_cnt_d  = CNT_W'(1);
          state_d     = BUSY;
        end
      end

      BUSY: begin
        if (!req[gnt_id_q]) begin
          // Owner released: hand over in the same edge so there is no idle gap.
          pick = next_owner(req, ptr_q, 1'b0);
          if (pick.found) begin
            gnt_id_d   = pick.idx;
            ptr_d      = pick.idx;
            hold_cnt_d = CNT_W'(1);
          end else begin
            gnt_valid_d = 1'b0;
            hold_cnt_d  = '0;
            state_d     = IDLE;
          end
        end else if (hold_cnt_q == CNT_W'(MAX_HOLD)) begin
          pick       = next_owner(req, ptr_q, 1'b1);
          hold_cnt_d = CNT_W'(1);
          if (pick.found) begin
            gnt_id_d  = pick.idx;
            ptr_d     = pick.idx;
            preempt_d = 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_id_q    <= 2'd0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= 2'd3;
      hold_cnt_q  <= '0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      preempt_q   <= preempt_d;
    end
  end

  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

  decoder_2to4_bh u_dec (
    .in  (gnt_id_q),
    .en  (gnt_valid_q),
    .out (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: vector table plus contention/lone-requester sequences.
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid, preempt;
  logic [3:0] req1, gnt1;
  logic [1:0] gnt_id1;
  logic       gnt_valid1, preempt1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .gnt_id(gnt_id), .gnt_valid(gnt_valid), .preempt(preempt)
  );

  rr_arbiter_4 #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .gnt(gnt1),
    .gnt_id(gnt_id1), .gnt_valid(gnt_valid1), .preempt(preempt1)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       vld;
    logic       pre;
  } vec_t;

  vec_t vt[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    logic [1:0] exp_id;
    logic       exp_pre;

    // Release after reset
    vt[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    // Voluntary release 0 -> 2 without a bubble
    vt[4]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    // Owner 2 drops with req=1001: index 3 wins, then 0
    vt[9]  = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
    vt[10] = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    // Reset mid-grant, then full request restarts at index 0
    vt[11] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vt[12] = '{1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[13] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
    vt[14] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

    rst  = 1'b1;
    req  = 4'b0000;
    req1 = 4'b0000;

    for (int i = 0; i < 15; i++) begin
      rst = vt[i].rst;
      req = vt[i].req;
      tick();
      check($sformatf("row%0d gnt", i),       32'(gnt),       32'(vt[i].gnt));
      check($sformatf("row%0d gnt_id", i),    32'(gnt_id),    32'(vt[i].id));
      check($sformatf("row%0d gnt_valid", i), 32'(gnt_valid), 32'(vt[i].vld));
      check($sformatf("row%0d preempt", i),   32'(preempt),   32'(vt[i].pre));
    end

    // Lone requester never gets preempted
    rst = 1'b1; req = 4'b0000; tick();
    rst = 1'b0; req = 4'b0010;
    for (int c = 1; c <= 20; c++) begin
      tick();
      check($sformatf("lone c%0d gnt", c), 32'(gnt), 32'h2);
      check($sformatf("lone c%0d preempt", c), 32'(preempt), 32'h0);
    end

    // Full contention with MAX_HOLD=8: 8-cycle turns, a pulse per handover
    rst = 1'b1; req = 4'b0000; tick();
    rst = 1'b0; req = 4'b1111;
    pulses = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      exp_id  = 2'(((c - 1) / 8) % 4);
      exp_pre = (c > 1) && (((c - 1) % 8) == 0);
      check($sformatf("cont c%0d gnt_id", c), 32'(gnt_id), 32'(exp_id));
      check($sformatf("cont c%0d preempt", c), 32'(preempt), 32'(exp_pre));
      if (preempt) pulses++;
    end
    check("cont pulses", 32'(pulses), 32'd4);
    req = 4'b0000;

    // MAX_HOLD=1: ownership rotates every cycle under contention
    rst = 1'b1; tick();
    rst = 1'b0; req1 = 4'b1111;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("mh1 c%0d gnt_id", c), 32'(gnt_id1), 32'((c - 1) % 4));
      check($sformatf("mh1 c%0d preempt", c), 32'(preempt1), 32'(c > 1));
    end
    req1 = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
Round-robin arbiter that shares one resource between 4 requesters.
- Issues a one-hot grant, with a registered owner index and grant-valid flag.
- A configurable hold limit stops any requester from monopolising the resource.
- The one-hot grant comes from the team's existing 2-to-4 enabled decoder, driven by the registered owner index. It feeds the downstream mux/enable logic that selects the active requester.

Parameters:
- MAX_HOLD, 8, max consecutive cycles one owner keeps the grant while others are requesting. Legal range 1..255.
- CNT_W, $clog2(MAX_HOLD+1), hold-counter width. Derived; must not be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  4  request lines. A requester holds its bit high for as long as it wants the resource.
- gnt  out  4  one-hot grant. All zero when gnt_valid=0.
- gnt_id  out  2  registered index of the current owner.
- gnt_valid  out  1  registered; high while a grant is held.
- preempt  out  1  registered one-cycle pulse when the hold limit forces an ownership change.

Behaviour:
- Clock and reset (already decided): one clock, clk. rst is synchronous and active-high, sampled only at the rising edge of clk. rst overrides all other activity, including mid-grant.
- Reset values:
  - state=IDLE, gnt_id=0, gnt_valid=0, gnt=0000, preempt=0.
  - hold_cnt=0, ptr=3, so the first arbitration searches from index 0.
- Priority order: search ptr+1, ptr+2, ptr+3, ptr, all mod 4. ptr is the index of the last owner.
- State IDLE:
  - If req!=0 at an edge, the first set bit in priority order wins.
  - At that edge: gnt_id<=winner, gnt_valid<=1, ptr<=winner, hold_cnt<=1, state<=BUSY.
  - Latency: gnt is visible one cycle after req is sampled.
- State BUSY, release (req[gnt_id]=0 at an edge):
  - Re-arbitrate at that same edge, with no bubble.
  - If another req bit is set, grant it: ptr<=winner, hold_cnt<=1, preempt<=0.
  - Otherwise: gnt_valid<=0, state<=IDLE.
- State BUSY, hold limit (req[gnt_id]=1 and hold_cnt==MAX_HOLD):
  - If any other req bit is set, grant the next in priority order, excluding the current owner. Set hold_cnt<=1 and pulse preempt<=1 for exactly one cycle.
  - If no other requester, keep the same owner, set hold_cnt<=1, preempt stays 0.
- State BUSY, otherwise: hold_cnt<=hold_cnt+1. hold_cnt saturates at MAX_HOLD and never wraps.
- Non-owner req changes during BUSY are ignored until the next re-arbitration edge.
- preempt is 0 in every cycle not described above.
- MAX_HOLD=1: under contention, ownership rotates every cycle.
- gnt is combinational from registered gnt_id/gnt_valid via the decoder (en=gnt_valid), so it is glitch-free relative to clk.
- No X propagation: every case and if statement has a default assignment.

Decomposition:
- Shared package/include arb_pkg:
  - N_REQ=4.
  - State encodings IDLE=1'b0 and BUSY=1'b1.
  - Priority-search function next_owner(req, ptr, exclude), which returns the index and a found flag.
- One sub-module, decoder_2to4_bh:
  - Reused unchanged for the gnt output.
  - in=gnt_id, en=gnt_valid, out=gnt.

Test Plan:
1. Release after reset: rst for 2 cycles, then req=0001.
   -> Next cycle: gnt=0001, gnt_id=0, gnt_valid=1.
   -> Drop req: one cycle later gnt=0000, gnt_valid=0.
2. Full contention: MAX_HOLD=8, req=1111 held for 40 cycles.
   -> Owners run 0,1,2,3,0, each for exactly 8 cycles.
   -> preempt pulses once per handover: 4 pulses in total.
3. Voluntary release: req=0101; owner 0 drops its req after 3 cycles.
   -> gnt goes 0001 to 0100 at the same edge, with no zero cycle.
   -> preempt stays 0.
4. Lone requester: req=0010 held for 20 cycles with MAX_HOLD=8.
   -> gnt stays 0010 throughout; preempt never asserts.
5. Reset mid-grant: rst asserted while gnt=0100.
   -> Next edge: gnt=0000, gnt_valid=0, preempt=0.
   -> After rst drops with req=1111: first gnt=0001.
6. Simultaneous release and new requests: owner 2 drops its req while req=1001.
   -> Next gnt=1000, because index 3 precedes index 0 from ptr=2.
   -> After index 3 releases: gnt=0001.
